fact_mmio: RTL and testbench
============================

// Module: fact_mmio
// PURPOSE
//  Memory-mapped wrapper around an iterative factorial engine. Occupies the 0x8xx window selected by the
//  SoC address decoder: consumes its WE1 strobe plus the CPU address/write data, and returns read data on
//  the RdSel=2'b10 leg of the read mux. Software writes n, writes GO, polls STATUS, then reads RESULT.
// PARAMETERS
//  DATA_W  32  bus and result width
//  N_W     4   width of the n operand register
//  N_MAX   12  largest n whose factorial fits DATA_W bits; n > N_MAX raises ERR
// PORTS
//  clk     in   1       system clock, rising edge
//  rst_n   in   1       asynchronous active-low reset
//  WE      in   1       write strobe from decoder (WE1); already qualified by the 0x8xx address window
//  A       in   2       word offset, bus A[3:2]: 0=N, 1=GO, 2=STATUS, 3=RESULT
//  WD      in   DATA_W  CPU write data
//  RD      out  DATA_W  read data, combinational from A
// BEHAVIOUR
//  Reset: n_reg=0, go_reg=0, done=0, err=0, result=0, core state IDLE; RD reflects these values immediately.
//  Register map (reads are combinational, writes take effect at the clk edge where WE=1):
//   A=0 N:      write n_reg<=WD[N_W-1:0]; read {zero-ext, n_reg}.
//   A=1 GO:     write of WD[0]=1 while core IDLE or DONE issues a one-cycle start; go_reg<=WD[0].
//               Ignored while core is BUSY (go_reg also unchanged). Read {31'b0, go_reg}.
//   A=2 STATUS: read-only {29'b0, busy, err, done}; writes ignored.
//   A=3 RESULT: read-only result; writes ignored.
//  Core FSM (sub-module), states IDLE, BUSY, DONE:
//   IDLE/DONE --start--> if n_reg > N_MAX: DONE, err=1, done=1, result=0 (at the start edge +1).
//                        else BUSY, cnt<=n_reg, prod<=1, done<=0, err<=0.
//   BUSY: per cycle, if cnt<=1 -> DONE, result<=prod, done<=1; else prod<=prod*cnt, cnt<=cnt-1.
//   DONE: holds result/done/err until next start. No automatic return to IDLE.
//  Latency: with start at edge t0, done/result valid after edge t0+max(n,1)+1
//   (n=0 or 1: 2 edges; n=5: 6 edges). busy=1 exactly while state==BUSY.
//  Arithmetic: prod is DATA_W bits; product truncated to DATA_W (cannot overflow for n<=N_MAX).
//   0! = 1! = 1.
//  n_reg is latched into cnt at start; later N writes during BUSY update n_reg but not the computation.
//  Simultaneous events: one WE per cycle, so only one register is written per edge; a GO written in the
//   same cycle the core reaches DONE is ignored (core still BUSY at that edge).
//  Reset mid-operation: asynchronous abort to reset values; no partial result retained.
// STRUCTURE
//  Shared package fact_pkg: register offsets (FACT_N=2'd0, FACT_GO=2'd1, FACT_STATUS=2'd2,
//   FACT_RESULT=2'd3), STATUS bit positions (DONE=0, ERR=1, BUSY=2), FSM state encoding, N_MAX default.
//  One sub-module: fact_core (FSM, cnt, prod, result, done/err/busy; ports clk, rst_n, start, n,
//   result, done, err, busy). fact_mmio holds n_reg, go_reg, start generation, and the read mux.
// TESTING
//  1. Reset with rst_n=0 mid-BUSY -> all reads return 0 immediately; STATUS=0 after release.
//  2. Write N=5, GO=1 -> STATUS busy=1 for 5 cycles, then STATUS=3'b001, RESULT=120 (0x78) at edge t0+6.
//  3. N=0 and N=1 -> RESULT=1, done after 2 edges; N=12 -> RESULT=479001600 (0x1C8CFC00).
//  4. N=13 then GO -> STATUS=3'b011, RESULT=0 one edge after GO; next N=3,GO clears err, RESULT=6.
//  5. During BUSY (N=10): write GO=1 and N=2 -> both ignored by core; RESULT=3628800, then N reads 2.
//  6. Writes to STATUS/RESULT, and WE=0 cycles with WD toggling -> no register changes.

Source files
------------

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial MMIO block: register offsets, STATUS bit
// positions, core state encoding and default sizing.
package fact_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int N_W_DEF    = 4;
    localparam int N_MAX_DEF  = 12;

    localparam logic [1:0] FACT_N      = 2'd0;
    localparam logic [1:0] FACT_GO     = 2'd1;
    localparam logic [1:0] FACT_STATUS = 2'd2;
    localparam logic [1:0] FACT_RESULT = 2'd3;

    localparam int STAT_DONE = 0;
    localparam int STAT_ERR  = 1;
    localparam int STAT_BUSY = 2;
    localparam int STAT_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } fact_state_t;

    function automatic logic [STAT_W-1:0] pack_status(input logic busy,
                                                      input logic err,
                                                      input logic done);
        logic [STAT_W-1:0] s;
        s            = '0;
        s[STAT_BUSY] = busy;
        s[STAT_ERR]  = err;
        s[STAT_DONE] = done;
        return s;
    endfunction

endpackage

// File: rtl/fact_core.sv
// Iterative factorial engine: multiplies down from n to 1, one step per clock,
// and holds the result with done/err until the next start.
module fact_core
    import fact_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_W    = N_W_DEF,
    parameter int N_MAX  = N_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [N_W-1:0]    n,
    output logic [DATA_W-1:0] result,
    output logic              done,
    output logic              err,
    output logic              busy
);

    fact_state_t       state;
    logic [N_W-1:0]    cnt;
    logic [DATA_W-1:0] prod;

    // The loop stops once cnt reaches 1, so 0! and 1! both fall out as the initial prod of 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            prod   <= '0;
            result <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        if (n > N_W'(N_MAX)) begin
                            state  <= ST_DONE;
                            result <= '0;
                            done   <= 1'b1;
                            err    <= 1'b1;
                            busy   <= 1'b0;
                        end else begin
                            state <= ST_BUSY;
                            cnt   <= n;
                            prod  <= DATA_W'(1);
                            done  <= 1'b0;
                            err   <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt <= N_W'(1)) begin
                        state  <= ST_DONE;
                        result <= prod;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                    end else begin
                        prod <= prod * DATA_W'(cnt);
                        cnt  <= cnt - N_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/fact_mmio.sv
// Bus-facing wrapper: N/GO registers, start pulse generation and the
// combinational read mux over N, GO, STATUS and RESULT.
module fact_mmio
    import fact_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int N_W    = N_W_DEF,
    parameter int N_MAX  = N_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              WE,
    input  logic [1:0]        A,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD
);

    logic [N_W-1:0]    n_reg;
    logic              go_reg;
    logic              start;
    logic              go_write;
    logic [DATA_W-1:0] result;
    logic              done;
    logic              err;
    logic              busy;
    logic              unused_wd;

    assign unused_wd = ^WD[DATA_W-1:N_W];

    // GO is refused while the core is busy, including the edge on which it finishes.
    assign go_write = WE && (A == FACT_GO) && !busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_reg  <= '0;
            go_reg <= 1'b0;
            start  <= 1'b0;
        end else begin
            start <= go_write && WD[0];
            if (WE && (A == FACT_N)) begin
                n_reg <= WD[N_W-1:0];
            end
            if (go_write) begin
                go_reg <= WD[0];
            end
        end
    end

    fact_core #(
        .DATA_W (DATA_W),
        .N_W    (N_W),
        .N_MAX  (N_MAX)
    ) u_core (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .n      (n_reg),
        .result (result),
        .done   (done),
        .err    (err),
        .busy   (busy)
    );

    always_comb begin
        RD = '0;
        case (A)
            FACT_N:      RD[N_W-1:0]    = n_reg;
            FACT_GO:     RD[0]          = go_reg;
            FACT_STATUS: RD[STAT_W-1:0] = pack_status(busy, err, done);
            FACT_RESULT: RD             = result;
            default:     RD             = '0;
        endcase
    end

endmodule

// File: tb/tb_fact_mmio.sv
// Directed bench for fact_mmio: software-style register sequences with
// hand-computed factorials, latencies and STATUS codes.
module tb_fact_mmio;
    import fact_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        WE;
    logic [1:0]  A;
    logic [31:0] WD;
    logic [31:0] RD;

    int checks = 0;
    int errors = 0;

    fact_mmio #(
        .DATA_W (32),
        .N_W    (4),
        .N_MAX  (12)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .WE    (WE),
        .A     (A),
        .WD    (WD),
        .RD    (RD)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // One bus write: drive on the falling edge, commit on the next rising edge.
    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        WE = 1'b1;
        A  = a;
        WD = d;
        @(posedge clk);
        #1;
        WE = 1'b0;
    endtask

    task automatic wait_edges(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check_reg(input logic [1:0] a, input logic [31:0] expv, input string tag);
        A = a;
        #1;
        checks++;
        assert (RD === expv)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, RD, expv);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        WE    = 1'b0;
        A     = FACT_N;
        WD    = '0;

        #5;
        check_reg(FACT_N,      32'd0, "reset_n");
        check_reg(FACT_GO,     32'd0, "reset_go");
        check_reg(FACT_STATUS, 32'd0, "reset_status");
        check_reg(FACT_RESULT, 32'd0, "reset_result");
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] n=5");
        write_reg(FACT_N, 32'd5);
        check_reg(FACT_N, 32'd5, "n5_readback");
        write_reg(FACT_GO, 32'd1);
        check_reg(FACT_GO,     32'd1, "n5_go_readback");
        check_reg(FACT_STATUS, 32'd0, "n5_status_t0");
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd4, "n5_busy_t1");
        wait_edges(4);
        check_reg(FACT_STATUS, 32'd4, "n5_busy_t5");
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd1, "n5_done_t6");
        check_reg(FACT_RESULT, 32'h0000_0078, "n5_result");

        $display("[TB] n=0, n=1, n=12");
        write_reg(FACT_N, 32'd0);
        write_reg(FACT_GO, 32'd1);
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd4, "n0_busy_t1");
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd1, "n0_done_t2");
        check_reg(FACT_RESULT, 32'd1, "n0_result");

        write_reg(FACT_N, 32'd1);
        write_reg(FACT_GO, 32'd1);
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd4, "n1_busy_t1");
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd1, "n1_done_t2");
        check_reg(FACT_RESULT, 32'd1, "n1_result");

        write_reg(FACT_N, 32'd12);
        write_reg(FACT_GO, 32'd1);
        wait_edges(12);
        check_reg(FACT_STATUS, 32'd4, "n12_busy_t12");
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd1, "n12_done_t13");
        check_reg(FACT_RESULT, 32'h1C8C_FC00, "n12_result");

        $display("[TB] n=13 error then n=3");
        write_reg(FACT_N, 32'd13);
        write_reg(FACT_GO, 32'd1);
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd3, "n13_err_status");
        check_reg(FACT_RESULT, 32'd0, "n13_result");

        write_reg(FACT_N, 32'd3);
        write_reg(FACT_GO, 32'd1);
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd4, "n3_err_cleared");
        wait_edges(2);
        check_reg(FACT_STATUS, 32'd4, "n3_busy_t3");
        wait_edges(1);
        check_reg(FACT_STATUS, 32'd1, "n3_done_t4");
        check_reg(FACT_RESULT, 32'd6, "n3_result");

        $display("[TB] writes during busy, n=10");
        write_reg(FACT_N, 32'd10);
        write_reg(FACT_GO, 32'd1);
        wait_edges(2);
        write_reg(FACT_GO, 32'd0);
        check_reg(FACT_GO, 32'd1, "busy_go_write_ignored");
        write_reg(FACT_N, 32'd2);
        check_reg(FACT_N,      32'd2, "busy_n_updates");
        check_reg(FACT_STATUS, 32'd4, "n10_busy_t4");
        wait_edges(6);
        check_reg(FACT_STATUS, 32'd4, "n10_busy_t10");
        write_reg(FACT_GO, 32'd1);
        check_reg(FACT_STATUS, 32'd1, "n10_done_t11");
        check_reg(FACT_RESULT, 32'h0037_5F00, "n10_result");
        wait_edges(2);
        check_reg(FACT_STATUS, 32'd1, "go_at_done_edge_ignored");
        check_reg(FACT_RESULT, 32'h0037_5F00, "n10_result_held");

        $display("[TB] read-only writes and idle bus");
        write_reg(FACT_STATUS, 32'hFFFF_FFFF);
        write_reg(FACT_RESULT, 32'h0000_0000);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            WE = 1'b0;
            A  = 2'(i);
            WD = 32'hA5A5_5A5A ^ 32'(i);
        end
        wait_edges(1);
        check_reg(FACT_N,      32'd2, "idle_n");
        check_reg(FACT_GO,     32'd1, "idle_go");
        check_reg(FACT_STATUS, 32'd1, "idle_status");
        check_reg(FACT_RESULT, 32'h0037_5F00, "idle_result");

        $display("[TB] reset during busy");
        write_reg(FACT_N, 32'd7);
        write_reg(FACT_GO, 32'd1);
        wait_edges(3);
        check_reg(FACT_STATUS, 32'd4, "pre_reset_busy");
        rst_n = 1'b0;
        check_reg(FACT_N,      32'd0, "abort_n");
        check_reg(FACT_GO,     32'd0, "abort_go");
        check_reg(FACT_STATUS, 32'd0, "abort_status");
        check_reg(FACT_RESULT, 32'd0, "abort_result");
        @(negedge clk);
        rst_n = 1'b1;
        wait_edges(2);
        check_reg(FACT_STATUS, 32'd0, "post_reset_status");
        check_reg(FACT_RESULT, 32'd0, "post_reset_result");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
